// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async-FIFO pointer parameters and Gray/binary helpers
package fifo_pkg;

  // Default geometry; the pointer/status controllers derive their own widths from ADDR_SIZE.
  localparam int ADDR_SIZE_DEF = 4;
  localparam int AF_MARGIN_DEF = 2;
  localparam int DEPTH         = 1 << ADDR_SIZE_DEF;
  localparam int PTR_W         = ADDR_SIZE_DEF + 1;

  // Width-agnostic helpers: callers zero-extend into 32 bits and cast the result back down.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down, done as a log-depth shift ladder.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    b = b ^ (b >> 16);
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational Gray-to-binary converter (XOR prefix)
module gray_to_bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at and above its position.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/wrt_ptr_full_ctrl.sv
// rtl/wrt_ptr_full_ctrl.sv - async FIFO write-domain pointer, full and level controller
module wrt_ptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int AF_MARGIN = AF_MARGIN_DEF
) (
  input  logic                 wrt_clk,
  input  logic                 wrt_rst,
  input  logic                 wrt_en,
  input  logic [ADDR_SIZE:0]   sync_rd_ptr,
  output logic [ADDR_SIZE:0]   wrt_ptr,
  output logic [ADDR_SIZE-1:0] wrt_addr,
  output logic                 mem_wen,
  output logic                 wrt_full,
  output logic                 wrt_almost_full,
  output logic                 wrt_overflow,
  output logic [ADDR_SIZE:0]   wrt_level
);

  localparam int PW    = ADDR_SIZE + 1;
  localparam int DEPTH_L = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] AF_THRESH = PW'(DEPTH_L - AF_MARGIN);

  logic [ADDR_SIZE:0] wbin_q, wbin_d;
  logic [ADDR_SIZE:0] gray_q, gray_d;
  logic [ADDR_SIZE:0] level_q, level_d;
  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] full_gray;
  logic               full_q, full_d;
  logic               af_q, af_d;
  logic               ovf_q, ovf_d;
  logic               push;

  gray_to_bin #(.W(PW)) u_rd_g2b (
    .gray_i (sync_rd_ptr),
    .bin_o  (rbin)
  );

  // Next pointer and status, all derived from the post-accept pointer and the synced read pointer
  // so a write and a read advance landing on the same edge are folded together.
  always_comb begin
    push      = wrt_en & ~full_q;
    wbin_d    = wbin_q + {{ADDR_SIZE{1'b0}}, push};
    gray_d    = PW'(bin2gray(32'(wbin_d)));
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_gray = {~sync_rd_ptr[ADDR_SIZE:ADDR_SIZE-1], sync_rd_ptr[ADDR_SIZE-2:0]};
    full_d    = (gray_d == full_gray);
    level_d   = wbin_d - rbin;
    af_d      = (level_d >= AF_THRESH);
    ovf_d     = wrt_en & full_q;
  end

  // Pointer and status registers; reset clears everything immediately.
  always_ff @(posedge wrt_clk or posedge wrt_rst) begin
    if (wrt_rst) begin
      wbin_q  <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  // The strobe is gated by reset so an in-flight request never reaches the RAM.
  assign mem_wen         = push & ~wrt_rst;
  assign wrt_addr        = wbin_q[ADDR_SIZE-1:0];
  assign wrt_ptr         = gray_q;
  assign wrt_full        = full_q;
  assign wrt_almost_full = af_q;
  assign wrt_overflow    = ovf_q;
  assign wrt_level       = level_q;

endmodule

// File: tb/tb_wrt_ptr_full_ctrl.sv
// tb/tb_wrt_ptr_full_ctrl.sv - self-checking bench for wrt_ptr_full_ctrl
module tb_wrt_ptr_full_ctrl;

  logic       wrt_clk = 1'b0;
  logic       wrt_rst = 1'b1;
  logic       wrt_en = 1'b0;
  logic [4:0] sync_rd_ptr = '0;
  logic [4:0] wrt_ptr;
  logic [3:0] wrt_addr;
  logic       mem_wen;
  logic       wrt_full;
  logic       wrt_almost_full;
  logic       wrt_overflow;
  logic [4:0] wrt_level;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: unbounded write/read totals; everything else follows from them.
  int wtot = 0;
  int rtot = 0;
  bit m_full = 0;
  bit ever_full_in_wrap = 0;

  wrt_ptr_full_ctrl #(.ADDR_SIZE(4), .AF_MARGIN(2)) dut (
    .wrt_clk         (wrt_clk),
    .wrt_rst         (wrt_rst),
    .wrt_en          (wrt_en),
    .sync_rd_ptr     (sync_rd_ptr),
    .wrt_ptr         (wrt_ptr),
    .wrt_addr        (wrt_addr),
    .mem_wen         (mem_wen),
    .wrt_full        (wrt_full),
    .wrt_almost_full (wrt_almost_full),
    .wrt_overflow    (wrt_overflow),
    .wrt_level       (wrt_level)
  );

  always #5 wrt_clk = ~wrt_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] to_gray(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  // One cycle: inputs applied at the falling edge, registered results checked at the next one.
  task automatic step(input bit en, input bit rd);
    int  lvl;
    bit  exp_ovf;
    int  exp_wen;
    if (rd && rtot < wtot) rtot++;
    wrt_en      = en;
    sync_rd_ptr = to_gray(rtot);
    #1;
    exp_wen = (en && !m_full) ? 1 : 0;
    check_eq("mem_wen", 32'(mem_wen), 32'(exp_wen));
    exp_ovf = en && m_full;
    if (exp_wen != 0) wtot++;
    @(posedge wrt_clk);
    @(negedge wrt_clk);
    lvl    = wtot - rtot;
    m_full = (lvl == 16);
    check_eq("level",    32'(wrt_level),       32'(lvl));
    check_eq("full",     32'(wrt_full),        32'(m_full));
    check_eq("afull",    32'(wrt_almost_full), 32'(lvl >= 14));
    check_eq("overflow", 32'(wrt_overflow),    32'(exp_ovf));
    check_eq("ptr",      32'(wrt_ptr),         32'(to_gray(wtot)));
    check_eq("addr",     32'(wrt_addr),        32'(wtot % 16));
    if (wrt_full) ever_full_in_wrap = 1;
  endtask

  task automatic do_reset();
    wrt_rst     = 1'b1;
    wrt_en      = 1'b0;
    sync_rd_ptr = '0;
    wtot = 0; rtot = 0; m_full = 0;
    @(posedge wrt_clk);
    @(negedge wrt_clk);
    wrt_rst = 1'b0;
  endtask

  initial begin
    @(negedge wrt_clk);
    do_reset();
    check_eq("rst_level", 32'(wrt_level), 0);
    check_eq("rst_ptr",   32'(wrt_ptr),   0);
    check_eq("rst_full",  32'(wrt_full),  0);
    check_eq("rst_addr",  32'(wrt_addr),  0);

    // Fill to full with the read pointer parked at zero.
    for (int i = 0; i < 16; i++) step(1, 0);
    check_eq("fill_full",  32'(wrt_full),  1);
    check_eq("fill_ptr",   32'(wrt_ptr),   32'h18);
    check_eq("fill_level", 32'(wrt_level), 16);

    // 17th request is dropped and flagged.
    step(1, 0);
    check_eq("ovf_pulse", 32'(wrt_overflow), 1);
    check_eq("ovf_addr",  32'(wrt_addr),     0);

    // One read frees a slot; the next write goes to address 0.
    step(0, 1);
    check_eq("rel_full",  32'(wrt_full),  0);
    check_eq("rel_level", 32'(wrt_level), 15);
    wrt_en = 1'b1;
    #1;
    check_eq("rel_wen",  32'(mem_wen),  1);
    check_eq("rel_addr", 32'(wrt_addr), 0);
    step(1, 0);

    // Almost-full threshold edges.
    do_reset();
    for (int i = 0; i < 13; i++) step(1, 0);
    check_eq("af_13", 32'(wrt_almost_full), 0);
    step(1, 0);
    check_eq("af_14", 32'(wrt_almost_full), 1);
    step(0, 1);
    check_eq("af_back13", 32'(wrt_almost_full), 0);

    // Wrap both pointers through 31 -> 0 with the FIFO nearly empty.
    do_reset();
    ever_full_in_wrap = 0;
    for (int i = 0; i < 31; i++) step(1, 1);
    step(0, 1);
    step(1, 0);
    step(0, 1);
    check_eq("wrap_ptr",   32'(wrt_ptr),   0);
    check_eq("wrap_level", 32'(wrt_level), 0);
    check_eq("wrap_nofull", 32'(ever_full_in_wrap), 0);

    // Randomized traffic, first write-heavy then read-heavy.
    for (int i = 0; i < 300; i++) step(($urandom % 4) != 0, ($urandom % 3) == 0);
    for (int i = 0; i < 300; i++) step(($urandom % 3) == 0, ($urandom % 4) != 0);
    for (int i = 0; i < 300; i++) step($urandom % 2, $urandom % 2);

    // Asynchronous reset mid-operation clears outputs before any clock edge.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0);
    #2;
    wrt_en  = 1'b1;
    wrt_rst = 1'b1;
    #1;
    check_eq("arst_level", 32'(wrt_level), 0);
    check_eq("arst_ptr",   32'(wrt_ptr),   0);
    check_eq("arst_addr",  32'(wrt_addr),  0);
    check_eq("arst_wen",   32'(mem_wen),   0);
    check_eq("arst_full",  32'(wrt_full),  0);
    check_eq("arst_ovf",   32'(wrt_overflow), 0);
    @(negedge wrt_clk);
    do_reset();
    wrt_en = 1'b1;
    #1;
    check_eq("post_rst_wen",  32'(mem_wen),  1);
    check_eq("post_rst_addr", 32'(wrt_addr), 0);
    step(1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
